ae_readout_ctrl: RTL and testbench
==================================

# ae_readout_ctrl

Parametrised serial readout controller for the acoustic-emission (AE) double-bank channel memory. It queues readout jobs raised by the acquisition side: a full-bank job when a bank fills, or a partial-bank job when an event ends. For each event it serialises a timestamp header followed by the memory words of every channel, MSB first, over a valid/ready bit stream. It sits between the bank memories / RTC and the serial link transmitter.

## Interface
Parameters:
- DEPTH, 200, words per bank (addresses 0..DEPTH-1)
- ADDR_W, 8, bank address width; 2^ADDR_W >= DEPTH
- WORD_W, 16, bits per channel word
- NCH, 2, channels read in parallel per address
- TS_W, 30, timestamp header width
- QDEPTH, 2, job queue depth (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- bank_full  in  1  one-cycle pulse: bank bank_id is full
- acq_done  in  1  one-cycle pulse: event ended in bank bank_id at last_addr
- bank_id  in  1  bank qualifying bank_full / acq_done
- last_addr  in  ADDR_W  last written address, valid with acq_done
- ts_in  in  TS_W  free-running RTC value
- mem_re  out  1  memory read enable
- mem_addr  out  ADDR_W+1  {bank, address}
- mem_rdata  in  NCH*WORD_W  read data, valid 1 cycle after mem_re; channel 0 in LSBs
- sout  out  1  serial bit
- sout_valid  out  1  sout holds a valid bit
- sout_ready  in  1  sink accepts the bit when sout_valid && sout_ready
- frame_start  out  1  high with the first header bit
- frame_end  out  1  high with the last bit of a partial job
- busy  out  1  state != IDLE or queue not empty
- overrun  out  1  sticky: a job was dropped on a full queue

## Operation
- Job queue, QDEPTH entries of {kind (full/partial), bank, end_addr}. bank_full pushes {full, bank_id, DEPTH-1}. acq_done pushes {partial, bank_id, min(last_addr, DEPTH-1)}.
- If bank_full and acq_done arrive in the same cycle, the full job is pushed first, then the partial job. A push onto a full queue is dropped and sets overrun. overrun clears only on reset.
- hdr_pending flag: set at reset and when a partial job completes; cleared when a header is sent.
- States:
  - IDLE: on queue non-empty, pop the job and clear addr. Go to TS_SHIFT if hdr_pending (capturing ts_in into the shift register), else RD_REQ.
  - TS_SHIFT: present TS_W bits MSB first. After the last bit is accepted, go to RD_REQ.
  - RD_REQ: mem_re=1 for one cycle with mem_addr={job bank, addr}. Go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into the NCH*WORD_W shift register. Go to SHIFT.
  - SHIFT: present channel 0 word MSB first, then channel 1, and so on.
- After the last bit of a word group is accepted:
  - if addr < end_addr: addr+1, go to RD_REQ;
  - otherwise the job is done: go to IDLE, or pop the next job directly and go to RD_REQ (or TS_SHIFT if hdr_pending is now set).
- A bit advances only on the accepting edge (sout_valid && sout_ready). sout and sout_valid hold while sout_ready=0.
- frame_start is combinational with the first header bit's sout_valid.
- frame_end is high while presenting the final bit of a partial job.
- The bit counter is sized to hold max(TS_W, NCH*WORD_W). Address arithmetic is ADDR_W bits and never wraps past end_addr.

## Timing
- Reset (asynchronous, any state) drives: state IDLE, queue empty, all outputs 0, hdr_pending=1, overrun=0, shift registers 0.
- Push to first bit: pulse at cycle N is enqueued at edge N. The job is popped at N+1 and sout_valid is high from N+2 (header).
- Read latency: mem_re at cycle R, data captured at R+1, first data bit valid at R+2.
- Per-address overhead: 2 cycles (RD_REQ, RD_WAIT) with sout_valid=0.
- With sout_ready held at 1, a full job after its header takes DEPTH*(NCH*WORD_W+2) cycles.
- Header: TS_W cycles with sout_ready=1.
- A job pushed while another is in flight starts with no IDLE cycle between jobs.
- sout_valid is never asserted in IDLE, RD_REQ or RD_WAIT.

## Test plan
- Reset, acq_done bank 0, last_addr=3, sout_ready=1:
  - frame_start with the first of 30 header bits equal to ts_in captured at pop;
  - then 4 reads at addresses {0,0..3}, 32 bits each, MSB first, channel 0 first;
  - frame_end on the last bit, then busy=0.
- bank_full bank 1, later acq_done bank 0, last_addr=0:
  - one header;
  - 200 reads at addresses 0x100..0x1C7;
  - then a single read at 0x000, frame_end, with no second header;
  - a following event gets a fresh header.
- sout_ready toggled pseudo-randomly:
  - the serial bit sequence is identical to the ready=1 run;
  - sout is stable while valid && !ready.
- Same-cycle bank_full+acq_done with an empty queue → full job served before the partial job. With QDEPTH=2 and 3 pushes while busy, the 3rd is dropped and overrun=1.
- acq_done with last_addr=250 (DEPTH=200) → clamped, reads stop at address 199.
- reset asserted during SHIFT: all outputs 0 asynchronously. The next job after release emits a header.

Source files
------------

// File: rtl/ae_readout_ctrl_if.sv
// Signal bundle between the AE readout controller, the bank memories / RTC
// and the serial link transmitter.
interface ae_readout_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 16,
   parameter int NCH    = 2,
   parameter int TS_W   = 30
);
   logic                    bank_full;
   logic                    acq_done;
   logic                    bank_id;
   logic [ADDR_W-1:0]       last_addr;
   logic [TS_W-1:0]         ts_in;
   logic                    mem_re;
   logic [ADDR_W:0]         mem_addr;
   logic [NCH*WORD_W-1:0]   mem_rdata;
   logic                    sout;
   logic                    sout_valid;
   logic                    sout_ready;
   logic                    frame_start;
   logic                    frame_end;
   logic                    busy;
   logic                    overrun;

   modport master (
      input  bank_full, acq_done, bank_id, last_addr, ts_in, mem_rdata, sout_ready,
      output mem_re, mem_addr, sout, sout_valid, frame_start, frame_end, busy, overrun
   );
   modport slave (
      output bank_full, acq_done, bank_id, last_addr, ts_in, mem_rdata, sout_ready,
      input  mem_re, mem_addr, sout, sout_valid, frame_start, frame_end, busy, overrun
   );
endinterface

// File: rtl/ae_readout_ctrl.sv
// AE double-bank readout: queues full/partial bank jobs and serialises a
// timestamp header plus every channel word, MSB first, over a valid/ready bit stream.
module ae_readout_ctrl #(
   parameter int DEPTH  = 200,
   parameter int ADDR_W = 8,
   parameter int WORD_W = 16,
   parameter int NCH    = 2,
   parameter int TS_W   = 30,
   parameter int QDEPTH = 2
) (
   input logic               clk,
   input logic               reset,
   ae_readout_ctrl_if.master bus
);
   localparam int GRP_W = NCH * WORD_W;
   localparam int SH_W  = (GRP_W > TS_W) ? GRP_W : TS_W;
   localparam int BC_W  = $clog2(SH_W + 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, TS_SHIFT, RD_REQ, RD_WAIT, SHIFT} state_e;
   typedef struct packed {
      logic              full;
      logic              bank;
      logic [ADDR_W-1:0] end_addr;
   } job_t;

   state_e            state_q;
   job_t              q_q [QDEPTH];
   job_t              q_d [QDEPTH];
   logic [2:0]        cnt_q, cnt_d;
   job_t              job_q;
   logic [ADDR_W-1:0] addr_q;
   logic [SH_W-1:0]   sreg_q;
   logic [BC_W-1:0]   bcnt_q;
   logic              hdr_pend_q;
   logic              overrun_q;

   logic              accept, hdr_last, grp_last, job_done, pop, next_hdr, drop;
   job_t              full_job, part_job;
   logic [SH_W-1:0]   hdr_load, grp_load;

   assign accept   = bus.sout_valid & bus.sout_ready;
   assign hdr_last = bcnt_q == BC_W'(TS_W - 1);
   assign grp_last = bcnt_q == BC_W'(GRP_W - 1);
   assign job_done = (state_q == SHIFT) && accept && grp_last && (addr_q == job_q.end_addr);
   assign pop      = (cnt_q != 3'd0) && ((state_q == IDLE) || job_done);
   // A partial job finishing this cycle forces a header on the job popped behind it.
   assign next_hdr = hdr_pend_q | (job_done & ~job_q.full);

   always_comb begin
      full_job          = '0;
      full_job.full     = 1'b1;
      full_job.bank     = bus.bank_id;
      full_job.end_addr = LAST_A;
      part_job          = '0;
      part_job.bank     = bus.bank_id;
      part_job.end_addr = (bus.last_addr > LAST_A) ? LAST_A : bus.last_addr;
   end

   // Pop happens before the pushes, then full job ahead of partial job.
   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      drop  = 1'b0;
      if (pop) begin
         for (int i = 0; i < QDEPTH - 1; i++) q_d[i] = q_q[i+1];
         q_d[QDEPTH-1] = '0;
         cnt_d = cnt_q - 3'd1;
      end
      if (bus.bank_full) begin
         if (cnt_d < 3'(QDEPTH)) begin
            for (int i = 0; i < QDEPTH; i++) if (3'(i) == cnt_d) q_d[i] = full_job;
            cnt_d = cnt_d + 3'd1;
         end else drop = 1'b1;
      end
      if (bus.acq_done) begin
         if (cnt_d < 3'(QDEPTH)) begin
            for (int i = 0; i < QDEPTH; i++) if (3'(i) == cnt_d) q_d[i] = part_job;
            cnt_d = cnt_d + 3'd1;
         end else drop = 1'b1;
      end
   end

   // Header and word group are left-aligned so the MSB of the register is always the next bit.
   always_comb begin
      hdr_load = '0;
      hdr_load[SH_W-1 -: TS_W] = bus.ts_in;
      grp_load = '0;
      for (int c = 0; c < NCH; c++)
         grp_load[SH_W-1-c*WORD_W -: WORD_W] = bus.mem_rdata[c*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         for (int i = 0; i < QDEPTH; i++) q_q[i] <= '0;
         cnt_q      <= '0;
         job_q      <= '0;
         addr_q     <= '0;
         sreg_q     <= '0;
         bcnt_q     <= '0;
         hdr_pend_q <= 1'b1;
         overrun_q  <= 1'b0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
         if (drop) overrun_q <= 1'b1;
         unique case (state_q)
            IDLE: state_q <= IDLE;
            TS_SHIFT: if (accept) begin
               sreg_q <= sreg_q << 1;
               bcnt_q <= bcnt_q + BC_W'(1);
               if (hdr_last) begin
                  bcnt_q  <= '0;
                  state_q <= RD_REQ;
               end
            end
            RD_REQ: state_q <= RD_WAIT;
            RD_WAIT: begin
               sreg_q  <= grp_load;
               bcnt_q  <= '0;
               state_q <= SHIFT;
            end
            SHIFT: if (accept) begin
               sreg_q <= sreg_q << 1;
               bcnt_q <= bcnt_q + BC_W'(1);
               if (grp_last) begin
                  bcnt_q <= '0;
                  if (addr_q != job_q.end_addr) begin
                     addr_q  <= addr_q + ADDR_W'(1);
                     state_q <= RD_REQ;
                  end else begin
                     if (!job_q.full) hdr_pend_q <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
         // Starting a job overrides the case above, so back-to-back jobs skip IDLE.
         if (pop) begin
            job_q  <= q_q[0];
            addr_q <= '0;
            bcnt_q <= '0;
            if (next_hdr) begin
               sreg_q     <= hdr_load;
               hdr_pend_q <= 1'b0;
               state_q    <= TS_SHIFT;
            end else begin
               state_q <= RD_REQ;
            end
         end
      end
   end

   assign bus.sout_valid  = (state_q == TS_SHIFT) || (state_q == SHIFT);
   assign bus.sout        = bus.sout_valid & sreg_q[SH_W-1];
   assign bus.mem_re      = state_q == RD_REQ;
   assign bus.mem_addr    = bus.mem_re ? {job_q.bank, addr_q} : '0;
   assign bus.frame_start = (state_q == TS_SHIFT) && (bcnt_q == '0);
   assign bus.frame_end   = (state_q == SHIFT) && !job_q.full && (addr_q == job_q.end_addr) && grp_last;
   assign bus.busy        = (state_q != IDLE) || (cnt_q != 3'd0);
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_ae_readout_ctrl.sv
// Bench for ae_readout_ctrl: a job-level model expands each pushed job into the
// expected bit stream; one compare process checks every accepted bit.
module tb_ae_readout_ctrl;
   localparam int DEPTH = 200, ADDR_W = 8, WORD_W = 16, NCH = 2, TS_W = 30, QDEPTH = 2;
   localparam int GRP_W = NCH * WORD_W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ae_readout_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .NCH(NCH), .TS_W(TS_W)) bus ();
   ae_readout_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .NCH(NCH),
                     .TS_W(TS_W), .QDEPTH(QDEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0, errors = 0;
   int cyc = 0;
   int push_cyc, fe_cyc, idle_cyc;
   logic [TS_W-1:0]   hdr_ts = '0;
   logic [ADDR_W:0]   last_rd = '0;
   logic [GRP_W-1:0]  rd_q = '0;
   bit rnd_ready = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   assign bus.ts_in     = TS_W'(cyc);
   assign bus.mem_rdata = rd_q;

   // Memory contents: a distinct word per {bank, address, channel}.
   function automatic logic [GRP_W-1:0] memf(input logic [ADDR_W:0] a);
      logic [GRP_W-1:0] r;
      for (int c = 0; c < NCH; c++)
         r[c*WORD_W +: WORD_W] = WORD_W'(32'(a) * 32'd40503 + 32'(c) * 32'd12345 + 32'h5A3C);
      return r;
   endfunction

   always @(posedge clk) if (bus.mem_re) rd_q <= memf(bus.mem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected stream model
   typedef struct { logic b; logic fs; logic fe; logic hdr; int hidx; } exp_t;
   exp_t expq[$];
   bit m_hdr_pend = 1'b1;

   task automatic model_push(input bit full, input bit bank, input int end_a);
      exp_t e;
      logic [GRP_W-1:0] w;
      if (m_hdr_pend) begin
         for (int j = 0; j < TS_W; j++) begin
            e.b = 1'b0; e.fs = (j == 0); e.fe = 1'b0; e.hdr = 1'b1; e.hidx = j;
            expq.push_back(e);
         end
         m_hdr_pend = 1'b0;
      end
      for (int a = 0; a <= end_a; a++) begin
         w = memf({bank, ADDR_W'(a)});
         for (int c = 0; c < NCH; c++)
            for (int k = WORD_W - 1; k >= 0; k--) begin
               e.b = w[c*WORD_W + k]; e.fs = 1'b0; e.hdr = 1'b0; e.hidx = 0;
               e.fe = !full && (a == end_a) && (c == NCH - 1) && (k == 0);
               expq.push_back(e);
            end
      end
      if (!full) m_hdr_pend = 1'b1;
   endtask

   task automatic pulse(input bit full, input bit done, input bit bank, input int last, input bit drop_done);
      @(posedge clk); #1;
      bus.bank_full = full; bus.acq_done = done; bus.bank_id = bank;
      bus.last_addr = ADDR_W'(last);
      push_cyc = cyc;
      if (full) model_push(1'b1, bank, DEPTH - 1);
      if (done && !drop_done) model_push(1'b0, bank, (last > DEPTH - 1) ? DEPTH - 1 : last);
      @(posedge clk); #1;
      bus.bank_full = 1'b0; bus.acq_done = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (bus.busy && n < budget);
      chk("idle_timeout", bus.busy, 0);
      idle_cyc = cyc;
   endtask

   task automatic wait_rd(input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (!bus.mem_re && n < budget);
      chk("read_timeout", bus.mem_re, 1);
   endtask

   initial begin
      bus.sout_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bus.sout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Compare process: every accepted bit, plus hold and qualifier rules each cycle.
   initial begin
      logic pv, pr, ps, pfs, eb;
      exp_t e;
      pv = 0; pr = 0; ps = 0; pfs = 0;
      forever begin
         @(negedge clk);
         if (reset) begin pv = 0; pr = 0; ps = 0; pfs = 0; continue; end
         if (bus.frame_start && !pfs) hdr_ts = TS_W'(cyc - 1);
         if (pv && !pr) begin
            chk("hold_valid", bus.sout_valid, 1);
            chk("hold_sout", bus.sout, ps);
         end
         if (bus.sout_valid) chk("no_read_while_valid", bus.mem_re, 0);
         if (bus.frame_start) chk("frame_start_valid", bus.sout_valid, 1);
         if (bus.mem_re) last_rd = bus.mem_addr;
         if (bus.sout_valid && bus.sout_ready) begin
            if (bus.frame_end) fe_cyc = cyc;
            if (expq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_bit: got sout=%0b required no bit", bus.sout);
            end else begin
               e = expq.pop_front();
               eb = e.hdr ? hdr_ts[TS_W-1-e.hidx] : e.b;
               chk("sout", bus.sout, eb);
               chk("frame_start", bus.frame_start, e.fs);
               chk("frame_end", bus.frame_end, e.fe);
            end
         end
         pv = bus.sout_valid; pr = bus.sout_ready; ps = bus.sout; pfs = bus.frame_start;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bus.bank_full = 1'b0; bus.acq_done = 1'b0; bus.bank_id = 1'b0; bus.last_addr = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sout_valid", bus.sout_valid, 0);
      chk("rst_sout", bus.sout, 0);
      chk("rst_mem_re", bus.mem_re, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_overrun", bus.overrun, 0);
      reset = 1'b0;

      // Short partial job, ready held high, exact timing
      pulse(0, 1, 0, 3, 0);
      n0 = push_cyc;
      chk("t1_pop_no_valid", bus.sout_valid, 0);
      chk("t1_busy", bus.busy, 1);
      @(posedge clk); #1;
      chk("t1_first_hdr_valid", bus.sout_valid, 1);
      chk("t1_first_frame_start", bus.frame_start, 1);
      repeat (30) @(posedge clk);
      #1;
      chk("t1_first_read", bus.mem_re, 1);
      chk("t1_first_addr", bus.mem_addr, 9'h000);
      wait_idle(2000);
      chk("t1_hdr_ts", hdr_ts, n0 + 1);
      chk("t1_frame_end_cyc", fe_cyc, n0 + 167);
      chk("t1_idle_cyc", idle_cyc, n0 + 168);
      chk("t1_drained", expq.size(), 0);

      // Full bank 1, then partial bank 0 queued behind it; then a fresh event
      pulse(1, 0, 1, 0, 0);
      wait_rd(100);
      chk("t2_first_addr", bus.mem_addr, 9'h100);
      repeat (200) @(posedge clk);
      pulse(0, 1, 0, 0, 0);
      wait_idle(8000);
      chk("t2_last_rd", last_rd, 9'h000);
      chk("t2_drained", expq.size(), 0);
      pulse(0, 1, 1, 1, 0);
      wait_idle(1000);
      chk("t2b_drained", expq.size(), 0);

      // Back-pressure
      rnd_ready = 1'b1;
      pulse(0, 1, 0, 5, 0);
      wait_idle(4000);
      chk("t3_drained", expq.size(), 0);
      rnd_ready = 1'b0;

      // Same-cycle full + partial
      pulse(1, 1, 0, 2, 0);
      wait_idle(8000);
      chk("t4a_drained", expq.size(), 0);
      chk("t4a_overrun", bus.overrun, 0);

      // Overflow: two jobs fit behind the running one, the third is dropped
      pulse(1, 0, 1, 0, 0);
      repeat (100) @(posedge clk);
      pulse(0, 1, 0, 1, 0);
      pulse(0, 1, 1, 0, 0);
      chk("t4b_no_overrun_yet", bus.overrun, 0);
      pulse(0, 1, 0, 2, 1);
      chk("t4b_overrun", bus.overrun, 1);
      wait_idle(9000);
      chk("t4b_drained", expq.size(), 0);
      chk("t4b_overrun_sticky", bus.overrun, 1);

      // Clamp of last_addr past the bank
      pulse(0, 1, 0, 250, 0);
      wait_idle(8000);
      chk("t5_last_rd", last_rd, 9'h0C7);
      chk("t5_drained", expq.size(), 0);

      // Asynchronous reset in the middle of a data word
      pulse(0, 1, 1, 3, 0);
      repeat (50) @(posedge clk);
      #1;
      chk("t6_in_shift", bus.sout_valid, 1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_sout_valid", bus.sout_valid, 0);
      chk("t6_rst_sout", bus.sout, 0);
      chk("t6_rst_mem_re", bus.mem_re, 0);
      chk("t6_rst_frame_start", bus.frame_start, 0);
      chk("t6_rst_frame_end", bus.frame_end, 0);
      chk("t6_rst_busy", bus.busy, 0);
      chk("t6_rst_overrun", bus.overrun, 0);
      expq.delete();
      m_hdr_pend = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      pulse(0, 1, 1, 0, 0);
      wait_idle(1000);
      chk("t6_drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
